ddr3_read_resp_matcher: RTL and testbench
=========================================

Name: ddr3_read_resp_matcher

Overview:
Downstream stage of the DDR3 controller FSM's read path. Pops the read-out address FIFO and the read-out data FIFO in lockstep, pairs each 128-bit line with its request address, and extracts the addressed 32-bit word. Presents the result to the core-side load unit over a valid/ready handshake. Watches for address/data FIFO skew and raises a sticky error.

Parameters:
ADDRESS_WIDTH, 32, request address width
DATA_WIDTH, 128, DDR3 line width (must equal WORD_WIDTH * power of two)
WORD_WIDTH, 32, core word width
WORD_SEL_LSB, 2, lowest address bit of the word index (byte-addressed words)
SKEW_TIMEOUT, 64, IDLE cycles with exactly one FIFO non-empty before sync_err sets (>=2)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
addr_fifo_empty  in  1  read-out address FIFO empty
addr_fifo_rdata  in  ADDRESS_WIDTH  address FIFO head, valid the cycle after addr_fifo_read
addr_fifo_read  out  1  address FIFO pop strobe
data_fifo_empty  in  1  read-out data FIFO empty
data_fifo_rdata  in  DATA_WIDTH  data FIFO head, valid the cycle after data_fifo_read
data_fifo_read  out  1  data FIFO pop strobe
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_addr  out  ADDRESS_WIDTH  request address of response
rsp_word  out  WORD_WIDTH  selected word
rsp_line  out  DATA_WIDTH  full line, for cache refill
sync_err  out  1  sticky FIFO skew error
rsp_count  out  32  count of accepted responses, wraps

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; skew counter 0; any captured response is dropped.
- FIFOs are non-fall-through: rdata is valid exactly one cycle after the read strobe.
- FSM states: IDLE, POP, CAPTURE, VALID.
- IDLE: if both FIFOs are non-empty, go to POP; otherwise stay.
- POP: addr_fifo_read=1 and data_fifo_read=1 for exactly this cycle (Moore outputs). Go to CAPTURE unconditionally.
- CAPTURE: register addr_fifo_rdata into rsp_addr and data_fifo_rdata into rsp_line. Set rsp_word = line slice at index addr[WORD_SEL_LSB +: log2(DATA_WIDTH/WORD_WIDTH)], with index 0 = bits [WORD_WIDTH-1:0]. Go to VALID.
- VALID: rsp_valid=1; rsp_addr, rsp_word and rsp_line are held stable while rsp_ready=0.
  - On rsp_ready=1: increment rsp_count (wraps at 2^32-1 to 0).
  - If both FIFOs are non-empty in that cycle, go directly to POP. Otherwise go to IDLE; rsp_valid drops the next cycle.
- Throughput: one response per 3 cycles back-to-back. Latency from both-non-empty in IDLE to rsp_valid is 3 cycles.
- Read strobes are never asserted outside POP. They are never asserted when either FIFO is empty, because POP is entered only on both non-empty and nothing else pops these FIFOs.
- Skew check, evaluated only in IDLE:
  - Exactly one FIFO non-empty: skew counter +1, saturating at SKEW_TIMEOUT.
  - Both or neither non-empty, or any state other than IDLE: counter clears.
  - Counter reaching SKEW_TIMEOUT sets sync_err=1, cleared only by rst. Operation otherwise continues.
- rsp_ready while rsp_valid=0 is ignored.

Decomposition:
- Shared package ddr3_pkg: state enum rsp_state_t {IDLE, POP, CAPTURE, VALID}; word-index width function; DDR3 command constants already used by the controller FSM.
- One natural sub-module, ddr3_word_select: combinational line-to-word mux parameterised by DATA_WIDTH, WORD_WIDTH, WORD_SEL_LSB.

Test Plan:
- Single response: addr FIFO holds 0x0000_0008, data FIFO holds 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA; rsp_ready=1 -> one POP pulse on both strobes; rsp_valid 3 cycles later with rsp_word=0xCCCC_CCCC, rsp_addr=0x8; rsp_count=1.
- Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid and payload held constant; no further strobes; on ready, a single handshake occurs and rsp_count increments by 1.
- Back-to-back: 4 entries queued, addresses 0x0, 0x4, 0x8, 0xC, same line -> words index 0..3 in order, one response every 3 cycles, rsp_count=4.
- Skew: address FIFO non-empty, data FIFO empty for 64 cycles -> sync_err=1 at cycle 64 and no read strobes. Data then arrives -> normal response; sync_err stays 1.
- Reset mid-response: assert rst while in VALID -> rsp_valid, strobes, rsp_count and sync_err go to 0 immediately (asynchronously). After release, FSM is in IDLE.
- Word-select boundary: addresses 0xFFFF_FFFC and 0x0000_0010 -> index 3 and index 0 respectively.

Source files
------------

// File: rtl/ddr3_pkg.sv
`default_nettype none
//------------------------------------------------------------------
// ddr3_pkg -- shared types and constants for the DDR3 read path. Rev 1.0
//------------------------------------------------------------------
package ddr3_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POP     = 2'd1,
    CAPTURE = 2'd2,
    VALID   = 2'd3
  } rsp_state_t;

  // Command encodings as {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_MRS   = 4'b0000;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_NOP   = 4'b0111;

  function automatic int word_idx_width(input int data_w, input int word_w);
    return $clog2(data_w / word_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ddr3_word_select.sv
`default_nettype none
//------------------------------------------------------------------
// ddr3_word_select -- combinational line-to-word mux, index 0 = LSBs. Rev 1.0
//------------------------------------------------------------------
module ddr3_word_select
  import ddr3_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int WORD_WIDTH = 32,
  localparam int SEL_WIDTH = word_idx_width(DATA_WIDTH, WORD_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] line,
  input  logic [SEL_WIDTH-1:0]  sel,
  output logic [WORD_WIDTH-1:0] word
);

  localparam int NUM_WORDS = DATA_WIDTH / WORD_WIDTH;

  logic [WORD_WIDTH-1:0] words [NUM_WORDS];

  for (genvar i = 0; i < NUM_WORDS; i++) begin : g_words
    assign words[i] = line[i*WORD_WIDTH +: WORD_WIDTH];
  end

  assign word = words[sel];

endmodule
`default_nettype wire

// File: rtl/ddr3_read_resp_matcher.sv
`default_nettype none
//------------------------------------------------------------------
// ddr3_read_resp_matcher -- pairs read addr/data FIFO heads into word responses. Rev 1.0
//------------------------------------------------------------------
module ddr3_read_resp_matcher
  import ddr3_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 128,
  parameter int WORD_WIDTH    = 32,
  parameter int WORD_SEL_LSB  = 2,
  parameter int SKEW_TIMEOUT  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     addr_fifo_empty,
  input  logic [ADDRESS_WIDTH-1:0] addr_fifo_rdata,
  output logic                     addr_fifo_read,
  input  logic                     data_fifo_empty,
  input  logic [DATA_WIDTH-1:0]    data_fifo_rdata,
  output logic                     data_fifo_read,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ADDRESS_WIDTH-1:0] rsp_addr,
  output logic [WORD_WIDTH-1:0]    rsp_word,
  output logic [DATA_WIDTH-1:0]    rsp_line,
  output logic                     sync_err,
  output logic [31:0]              rsp_count
);

  localparam int SEL_WIDTH = word_idx_width(DATA_WIDTH, WORD_WIDTH);
  localparam int SKEW_CW   = $clog2(SKEW_TIMEOUT + 1);
  localparam logic [SKEW_CW-1:0] SKEW_MAX = SKEW_CW'(SKEW_TIMEOUT);

  rsp_state_t          state, state_next;
  logic [SKEW_CW-1:0]  skew_cnt, skew_next;
  logic                both_ready, one_ready;
  logic [WORD_WIDTH-1:0] word_sel;

  assign both_ready = !addr_fifo_empty && !data_fifo_empty;
  assign one_ready  = addr_fifo_empty ^ data_fifo_empty;

  ddr3_word_select #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_word_select (
    .line (data_fifo_rdata),
    .sel  (addr_fifo_rdata[WORD_SEL_LSB +: SEL_WIDTH]),
    .word (word_sel)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (both_ready) state_next = POP;
      POP:     state_next = CAPTURE;
      CAPTURE: state_next = VALID;
      VALID:   if (rsp_ready) state_next = both_ready ? POP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Skew is only meaningful while idle; any activity restarts the window.
  always_comb begin
    skew_next = '0;
    if (state == IDLE && one_ready)
      skew_next = (skew_cnt == SKEW_MAX) ? skew_cnt : skew_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      skew_cnt  <= '0;
      sync_err  <= 1'b0;
      rsp_addr  <= '0;
      rsp_word  <= '0;
      rsp_line  <= '0;
      rsp_count <= '0;
    end else begin
      state    <= state_next;
      skew_cnt <= skew_next;
      if (skew_next == SKEW_MAX)
        sync_err <= 1'b1;
      if (state == CAPTURE) begin
        rsp_addr <= addr_fifo_rdata;
        rsp_line <= data_fifo_rdata;
        rsp_word <= word_sel;
      end
      if (state == VALID && rsp_ready)
        rsp_count <= rsp_count + 32'd1;
    end
  end

  assign addr_fifo_read = (state == POP);
  assign data_fifo_read = (state == POP);
  assign rsp_valid      = (state == VALID);

endmodule
`default_nettype wire

// File: tb/tb_ddr3_read_resp_matcher.sv
`default_nettype none
//------------------------------------------------------------------
// tb_ddr3_read_resp_matcher -- directed and random checks against a FIFO/scoreboard model. Rev 1.0
//------------------------------------------------------------------
module tb_ddr3_read_resp_matcher;

  localparam int AW = 32;
  localparam int DW = 128;
  localparam int WW = 32;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          addr_fifo_empty, addr_fifo_read;
  logic          data_fifo_empty, data_fifo_read;
  logic [AW-1:0] addr_fifo_rdata = '0;
  logic [DW-1:0] data_fifo_rdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [AW-1:0] rsp_addr;
  logic [WW-1:0] rsp_word;
  logic [DW-1:0] rsp_line;
  logic          sync_err;
  logic [31:0]   rsp_count;

  int n_cmp = 0;
  int n_fail = 0;

  ddr3_read_resp_matcher dut (
    .clk             (clk),
    .rst             (rst),
    .addr_fifo_empty (addr_fifo_empty),
    .addr_fifo_rdata (addr_fifo_rdata),
    .addr_fifo_read  (addr_fifo_read),
    .data_fifo_empty (data_fifo_empty),
    .data_fifo_rdata (data_fifo_rdata),
    .data_fifo_read  (data_fifo_read),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_addr        (rsp_addr),
    .rsp_word        (rsp_word),
    .rsp_line        (rsp_line),
    .sync_err        (sync_err),
    .rsp_count       (rsp_count)
  );

  always #5 clk = ~clk;

  // Non-fall-through FIFO models; their storage doubles as the scoreboard.
  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  int a_wr = 0, a_rd = 0, d_wr = 0, d_rd = 0;
  int cyc = 0;

  assign addr_fifo_empty = (a_wr == a_rd);
  assign data_fifo_empty = (d_wr == d_rd);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (addr_fifo_read && a_rd != a_wr) begin
      addr_fifo_rdata <= addr_mem[a_rd % DEPTH];
      a_rd <= a_rd + 1;
    end
    if (data_fifo_read && d_rd != d_wr) begin
      data_fifo_rdata <= data_mem[d_rd % DEPTH];
      d_rd <= d_rd + 1;
    end
  end

  int          hs_pos = 0;
  logic [31:0] exp_count = '0;
  logic        exp_sync = 1'b0;
  bit          chk_sync = 1'b1;
  bit          mon_en = 1'b0;

  function automatic logic [WW-1:0] pick_word(input logic [AW-1:0] a, input logic [DW-1:0] l);
    logic [DW-1:0] sh;
    int idx;
    idx = int'((a / 4) % 4);
    sh = l >> (idx * WW);
    return sh[WW-1:0];
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_addr(input logic [AW-1:0] a);
    addr_mem[a_wr % DEPTH] = a;
    a_wr++;
  endtask

  task automatic push_data(input logic [DW-1:0] l);
    data_mem[d_wr % DEPTH] = l;
    d_wr++;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int k = 0;
    while (!rsp_valid && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, {127'd0, rsp_valid}, 128'd1);
  endtask

  // Continuous monitor: handshakes against FIFO order, count, sticky error, strobe legality.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("rsp_count", {96'd0, rsp_count}, {96'd0, exp_count});
      if (chk_sync)
        check("sync_err", {127'd0, sync_err}, {127'd0, exp_sync});
      if (addr_fifo_read || data_fifo_read) begin
        check("strobe_pair", {126'd0, addr_fifo_read, data_fifo_read}, 128'd3);
        check("strobe_nonempty", {126'd0, addr_fifo_empty, data_fifo_empty}, 128'd0);
      end
      if (rsp_valid && rsp_ready) begin
        check("hs_addr", {96'd0, rsp_addr}, {96'd0, addr_mem[hs_pos % DEPTH]});
        check("hs_word", {96'd0, rsp_word},
              {96'd0, pick_word(addr_mem[hs_pos % DEPTH], data_mem[hs_pos % DEPTH])});
        check("hs_line", rsp_line, data_mem[hs_pos % DEPTH]);
        hs_pos++;
        exp_count++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  logic [DW-1:0] line_a;
  logic [DW-1:0] line_b;
  logic [WW-1:0] bw [4];
  logic [AW-1:0] ra;
  logic [DW-1:0] rl;
  int t_prev;
  int na, nd;

  initial begin
    line_a = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
    bw[0] = 32'h1111_1111; bw[1] = 32'h2222_2222;
    bw[2] = 32'h3333_3333; bw[3] = 32'h4444_4444;
    line_b = {bw[3], bw[2], bw[1], bw[0]};

    // Reset state
    rst = 1'b1;
    tick(2);
    check("rst_valid", {127'd0, rsp_valid}, 128'd0);
    check("rst_strobes", {126'd0, addr_fifo_read, data_fifo_read}, 128'd0);
    check("rst_count", {96'd0, rsp_count}, 128'd0);
    check("rst_sync", {127'd0, sync_err}, 128'd0);
    check("rst_payload", {rsp_addr, rsp_word}, 128'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick(2);

    // Single response with latency/strobe timing
    rsp_ready = 1'b1;
    push_addr(32'h0000_0008);
    push_data(line_a);
    tick(1);
    check("pop_strobe", {126'd0, addr_fifo_read, data_fifo_read}, 128'd3);
    tick(1);
    check("pop_once", {126'd0, addr_fifo_read, data_fifo_read}, 128'd0);
    check("valid_early", {127'd0, rsp_valid}, 128'd0);
    tick(1);
    check("latency3", {127'd0, rsp_valid}, 128'd1);
    check("single_word", {96'd0, rsp_word}, {96'd0, 32'hCCCC_CCCC});
    check("single_addr", {96'd0, rsp_addr}, 128'h8);
    tick(1);
    check("single_count", {96'd0, rsp_count}, 128'd1);
    check("valid_drop", {127'd0, rsp_valid}, 128'd0);
    tick(2);

    // Backpressure: payload held, no pops while waiting
    rsp_ready = 1'b0;
    push_addr(32'h0000_0024);
    push_data(line_b);
    wait_valid("bp_wait", 10);
    push_addr(32'h0000_0030);
    push_data(line_a);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("bp_valid", {127'd0, rsp_valid}, 128'd1);
      check("bp_addr", {96'd0, rsp_addr}, 128'h24);
      check("bp_word", {96'd0, rsp_word}, {96'd0, bw[1]});
      check("bp_line", rsp_line, line_b);
      check("bp_nostrobe", {126'd0, addr_fifo_read, data_fifo_read}, 128'd0);
    end
    rsp_ready = 1'b1;
    tick(1);
    check("bp_count", {96'd0, rsp_count}, 128'd2);
    check("bp_direct_pop", {126'd0, addr_fifo_read, data_fifo_read}, 128'd3);
    wait_valid("bp_second", 10);
    check("bp_second_word", {96'd0, rsp_word}, {96'd0, 32'hAAAA_AAAA});
    tick(1);
    check("bp_count2", {96'd0, rsp_count}, 128'd3);
    tick(2);

    // Back-to-back: four words of one line, one response every 3 cycles
    for (int k = 0; k < 4; k++) begin
      push_addr(AW'(4 * k));
      push_data(line_b);
    end
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_valid("b2b_wait", 10);
      check("b2b_word", {96'd0, rsp_word}, {96'd0, bw[k]});
      if (k > 0)
        check("b2b_gap", 128'(cyc - t_prev), 128'd3);
      t_prev = cyc;
      tick(1);
    end
    check("b2b_count", {96'd0, rsp_count}, 128'd7);
    tick(2);

    // Word-select boundaries
    push_addr(32'hFFFF_FFFC);
    push_data(line_b);
    push_addr(32'h0000_0010);
    push_data(line_b);
    wait_valid("bnd_wait_hi", 10);
    check("bnd_word_hi", {96'd0, rsp_word}, {96'd0, bw[3]});
    tick(1);
    wait_valid("bnd_wait_lo", 10);
    check("bnd_word_lo", {96'd0, rsp_word}, {96'd0, bw[0]});
    tick(3);

    // Randomized traffic with loosely coupled FIFO pushes and random ready
    na = 0;
    nd = 0;
    for (int c = 0; c < 2000 && (na < 24 || nd < 24 || hs_pos < a_wr); c++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (na < 24 && $urandom_range(0, 1) == 1) begin
        ra = $urandom;
        push_addr(ra);
        na++;
      end
      if (nd < 24 && $urandom_range(0, 1) == 1) begin
        rl = {$urandom, $urandom, $urandom, $urandom};
        push_data(rl);
        nd++;
      end
      tick(1);
    end
    check("rand_drained", 128'(hs_pos), 128'(a_wr));
    check("rand_count", {96'd0, rsp_count}, 128'd33);
    rsp_ready = 1'b1;
    tick(3);

    // Skew: address only for SKEW_TIMEOUT idle cycles
    chk_sync = 1'b0;
    push_addr(32'h0000_0044);
    tick(63);
    check("skew_pre", {127'd0, sync_err}, 128'd0);
    tick(1);
    check("skew_set", {127'd0, sync_err}, 128'd1);
    exp_sync = 1'b1;
    chk_sync = 1'b1;
    push_data(line_b);
    wait_valid("skew_resp", 10);
    check("skew_word", {96'd0, rsp_word}, {96'd0, bw[1]});
    tick(3);
    check("skew_sticky", {127'd0, sync_err}, 128'd1);
    check("skew_count", {96'd0, rsp_count}, 128'd34);

    // Asynchronous reset while a response is held
    rsp_ready = 1'b0;
    push_addr(32'h0000_0014);
    push_data(line_a);
    wait_valid("rst_mid_wait", 10);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", {127'd0, rsp_valid}, 128'd0);
    check("arst_strobes", {126'd0, addr_fifo_read, data_fifo_read}, 128'd0);
    check("arst_count", {96'd0, rsp_count}, 128'd0);
    check("arst_sync", {127'd0, sync_err}, 128'd0);
    exp_count = '0;
    exp_sync = 1'b0;
    hs_pos = a_rd;
    tick(2);
    rst = 1'b0;
    tick(2);
    check("post_rst_idle", {125'd0, rsp_valid, addr_fifo_read, data_fifo_read}, 128'd0);
    rsp_ready = 1'b1;
    push_addr(32'h0000_000C);
    push_data(line_a);
    tick(1);
    check("post_rst_pop", {126'd0, addr_fifo_read, data_fifo_read}, 128'd3);
    tick(2);
    check("post_rst_valid", {127'd0, rsp_valid}, 128'd1);
    check("post_rst_word", {96'd0, rsp_word}, {96'd0, 32'hDDDD_DDDD});
    tick(1);
    check("post_rst_count", {96'd0, rsp_count}, 128'd1);
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
